// File: rtl/tmr_fault_manager.sv
// TMR fault manager: vote classification, checkpointing, resync/rollback control.
// Optional TMR_FAULT_LOG_EN adds fault_log_pc / fault_log_total outputs.
module tmr_fault_manager #(
  parameter int unsigned FAULT_THRESH = 4,
  parameter int unsigned CNT_W        = 4,
  parameter int unsigned MAX_ROLLBACK = 3,
  parameter int unsigned ACK_TIMEOUT  = 64,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        vote_valid,
  input  logic [2:0]  Voter_state,
  input  logic [31:0] PC_Top,
  input  logic        MemWrite,
  input  logic        resync_ack,
  input  logic        rollback_ack,
  output logic        mem_write_safe,
  output logic        resync_req,
  output logic [31:0] resync_pc,
  output logic        rollback_req,
  output logic [31:0] rollback_pc,
  output logic [2:0]  fault_core,
  output logic [2:0]  core_disable,
  output logic        stall_out,
  output logic        halt
`ifdef TMR_FAULT_LOG_EN
  ,
  output logic [31:0] fault_log_pc,
  output logic [15:0] fault_log_total
`endif
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int RB_W   = $clog2(MAX_ROLLBACK + 1) < 1 ? 1 : $clog2(MAX_ROLLBACK + 1);

  typedef enum logic [1:0] {IDLE, RESYNC, ROLLBACK, HALT} state_t;

  state_t                st_q, st_d;
  logic [31:0]           ckpt_q, ckpt_d;
  logic [31:0]           rspc_q, rspc_d;
  logic [31:0]           rbpc_q, rbpc_d;
  logic [RB_W-1:0]       rb_q, rb_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            dis_q, dis_d;
  logic [2:0]            fc_q, fc_d;
  logic                  rs_q, rb_req_q, stall_q, halt_q;

  // Voter_state = {A==B, B==C, A==C}; fsel is one-hot {C,B,A} faulty core
  logic       agree, nomaj;
  logic [2:0] fsel;
  assign agree = (Voter_state == 3'b111);
  assign fsel  = {Voter_state == 3'b100, Voter_state == 3'b001,
                  Voter_state == 3'b010};
  assign nomaj = !agree && (fsel == 3'b000);

  // Stores only pass through on a clean or single-fault vote while idle
  assign mem_write_safe = MemWrite & vote_valid & (st_q == IDLE) & ~nomaj;

  // Next-state: vote handling in IDLE, ack/timeout handling in recovery
  always_comb begin
    st_d   = st_q;
    ckpt_d = ckpt_q;
    rspc_d = rspc_q;
    rbpc_d = rbpc_q;
    rb_d   = rb_q;
    wait_d = wait_q;
    cnt_d  = cnt_q;
    dis_d  = dis_q;
    fc_d   = fc_q;
    unique case (st_q)
      IDLE: begin
        if (vote_valid) begin
          if (agree) begin
            ckpt_d = PC_Top;
            if (PC_Top != rbpc_q) rb_d = '0;
          end else if (nomaj) begin
            if (rb_q == RB_W'(MAX_ROLLBACK)) begin
              st_d = HALT;
            end else begin
              rb_d   = rb_q + RB_W'(1);
              rbpc_d = ckpt_q;
              wait_d = '0;
              st_d   = ROLLBACK;
            end
          end else begin
            for (int i = 0; i < 3; i++) begin
              if (fsel[i] && !dis_q[i]) begin
                if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
                if (cnt_d[i] == CNT_W'(FAULT_THRESH)) begin
                  dis_d[i] = 1'b1;
                end else begin
                  rspc_d   = PC_Top;
                  fc_d     = '0;
                  fc_d[i]  = 1'b1;
                  wait_d   = '0;
                  st_d     = RESYNC;
                end
              end
            end
          end
        end
        // Two or more retired cores leave no majority to recover with
        if ((dis_d[0] & dis_d[1]) | (dis_d[1] & dis_d[2]) |
            (dis_d[0] & dis_d[2]))
          st_d = HALT;
      end
      RESYNC: begin
        if (resync_ack) begin
          fc_d = '0;
          st_d = IDLE;
        end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
          st_d = HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ROLLBACK: begin
        if (rollback_ack) begin
          st_d = IDLE;
        end else if (wait_q == WAIT_W'(ACK_TIMEOUT - 1)) begin
          st_d = HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      HALT: st_d = HALT;
    endcase
    if (st_d == HALT) fc_d = '0;
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      st_q     <= IDLE;
      ckpt_q   <= RESET_PC;
      rspc_q   <= '0;
      rbpc_q   <= '0;
      rb_q     <= '0;
      wait_q   <= '0;
      cnt_q    <= '0;
      dis_q    <= '0;
      fc_q     <= '0;
      rs_q     <= 1'b0;
      rb_req_q <= 1'b0;
      stall_q  <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      ckpt_q   <= ckpt_d;
      rspc_q   <= rspc_d;
      rbpc_q   <= rbpc_d;
      rb_q     <= rb_d;
      wait_q   <= wait_d;
      cnt_q    <= cnt_d;
      dis_q    <= dis_d;
      fc_q     <= fc_d;
      rs_q     <= (st_d == RESYNC);
      rb_req_q <= (st_d == ROLLBACK);
      stall_q  <= (st_d != IDLE);
      halt_q   <= (st_d == HALT);
    end
  end

  assign resync_req   = rs_q;
  assign resync_pc    = rspc_q;
  assign rollback_req = rb_req_q;
  assign rollback_pc  = rbpc_q;
  assign fault_core   = fc_q;
  assign core_disable = dis_q;
  assign stall_out    = stall_q;
  assign halt         = halt_q;

`ifdef TMR_FAULT_LOG_EN
  logic [31:0] lpc_q;
  logic [15:0] ltot_q;
  logic        log_hit;
  assign log_hit = (st_q == IDLE) & vote_valid & (nomaj | (|(fsel & ~dis_q)));

  // Record PC of the latest detected fault and a saturating total
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      lpc_q  <= '0;
      ltot_q <= '0;
    end else if (log_hit) begin
      lpc_q <= PC_Top;
      if (ltot_q != 16'hFFFF) ltot_q <= ltot_q + 16'd1;
    end
  end

  assign fault_log_pc    = lpc_q;
  assign fault_log_total = ltot_q;
`endif

endmodule

// File: tb/tb_tmr_fault_manager.sv
// Testbench for tmr_fault_manager: vector table with scoreboard queue
// plus hand sequences for threshold, rollback limit, timeout and reset.
module tb_tmr_fault_manager;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        vote_valid;
  logic [2:0]  Voter_state;
  logic [31:0] PC_Top;
  logic        MemWrite, resync_ack, rollback_ack;
  logic        mem_write_safe, resync_req, rollback_req;
  logic [31:0] resync_pc, rollback_pc;
  logic [2:0]  fault_core, core_disable;
  logic        stall_out, halt;
`ifdef TMR_FAULT_LOG_EN
  logic [31:0] fault_log_pc;
  logic [15:0] fault_log_total;
`endif

  tmr_fault_manager dut (
    .clk(clk), .rst_in(rst_in), .vote_valid(vote_valid),
    .Voter_state(Voter_state), .PC_Top(PC_Top), .MemWrite(MemWrite),
    .resync_ack(resync_ack), .rollback_ack(rollback_ack),
    .mem_write_safe(mem_write_safe), .resync_req(resync_req),
    .resync_pc(resync_pc), .rollback_req(rollback_req),
    .rollback_pc(rollback_pc), .fault_core(fault_core),
    .core_disable(core_disable), .stall_out(stall_out), .halt(halt)
`ifdef TMR_FAULT_LOG_EN
    , .fault_log_pc(fault_log_pc), .fault_log_total(fault_log_total)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic vv; logic [2:0] vs; logic [31:0] pc; logic mw;
    logic mws; logic rs; logic rb; logic [2:0] fc;
    logic [31:0] rspc; logic [31:0] rbpc;
  } vec_t;

  typedef struct {
    int idx; logic rs; logic rb; logic [2:0] fc;
    logic [31:0] rspc; logic [31:0] rbpc;
  } exp_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    vote_valid   = 1'b0;
    Voter_state  = 3'b111;
    PC_Top       = 32'h0;
    MemWrite     = 1'b0;
    resync_ack   = 1'b0;
    rollback_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic vote(input logic [2:0] vs, input logic [31:0] pc,
                      input logic mw);
    @(negedge clk);
    vote_valid  = 1'b1;
    Voter_state = vs;
    PC_Top      = pc;
    MemWrite    = mw;
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack_rs();
    @(negedge clk);
    resync_ack = 1'b1;
    @(posedge clk);
    #1;
    resync_ack = 1'b0;
  endtask

  task automatic ack_rb();
    @(negedge clk);
    rollback_ack = 1'b1;
    @(posedge clk);
    #1;
    rollback_ack = 1'b0;
  endtask

  vec_t tbl[13];

  initial begin
    exp_t e;
    logic held;

    tbl[0]  = '{1'b1, 3'b111, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0,  32'h0};
    tbl[1]  = '{1'b0, 3'b111, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0,  32'h0};
    tbl[2]  = '{1'b0, 3'b000, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0,  32'h0};
    tbl[3]  = '{1'b1, 3'b100, 32'h44, 1'b1, 1'b1, 1'b1, 1'b0, 3'b100, 32'h44, 32'h0};
    tbl[4]  = '{1'b1, 3'b010, 32'h48, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 32'h48, 32'h0};
    tbl[5]  = '{1'b1, 3'b001, 32'h4C, 1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 32'h4C, 32'h0};
    tbl[6]  = '{1'b1, 3'b000, 32'h50, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,  32'h40};
    tbl[7]  = '{1'b1, 3'b111, 32'h60, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0,  32'h40};
    tbl[8]  = '{1'b1, 3'b011, 32'h64, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,  32'h60};
    tbl[9]  = '{1'b1, 3'b101, 32'h68, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,  32'h60};
    tbl[10] = '{1'b1, 3'b110, 32'h6C, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,  32'h60};
    tbl[11] = '{1'b1, 3'b111, 32'h70, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0,  32'h60};
    tbl[12] = '{1'b1, 3'b110, 32'h74, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0,  32'h70};

    // reset state
    do_reset();
    chk("rst_resync_req", {31'b0, resync_req}, 32'h0);
    chk("rst_rollback_req", {31'b0, rollback_req}, 32'h0);
    chk("rst_stall", {31'b0, stall_out}, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    chk("rst_core_disable", {29'b0, core_disable}, 32'h0);
    chk("rst_rollback_pc", rollback_pc, 32'h0);

    // table: each row starts and ends in IDLE
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      vote_valid  = tbl[i].vv;
      Voter_state = tbl[i].vs;
      PC_Top      = tbl[i].pc;
      MemWrite    = tbl[i].mw;
      #1;
      chk($sformatf("t%0d_mws", i), {31'b0, mem_write_safe},
          {31'b0, tbl[i].mws});
      sb.push_back('{i, tbl[i].rs, tbl[i].rb, tbl[i].fc,
                     tbl[i].rspc, tbl[i].rbpc});
      @(posedge clk);
      #1;
      idle_in();
      e = sb.pop_front();
      chk($sformatf("t%0d_resync_req", e.idx), {31'b0, resync_req},
          {31'b0, e.rs});
      chk($sformatf("t%0d_rollback_req", e.idx), {31'b0, rollback_req},
          {31'b0, e.rb});
      chk($sformatf("t%0d_fault_core", e.idx), {29'b0, fault_core},
          {29'b0, e.fc});
      chk($sformatf("t%0d_rollback_pc", e.idx), rollback_pc, e.rbpc);
      if (e.rs) begin
        chk($sformatf("t%0d_resync_pc", e.idx), resync_pc, e.rspc);
        ack_rs();
        chk($sformatf("t%0d_stall_after_ack", e.idx), {31'b0, stall_out}, 32'h0);
      end
      if (e.rb) begin
        ack_rb();
        chk($sformatf("t%0d_stall_after_ack", e.idx), {31'b0, stall_out}, 32'h0);
      end
    end

    // resync hold, stray ack / vote ignored, ack + fault same cycle
    do_reset();
    vote(3'b100, 32'h44, 1'b0);
    chk("hold_stall", {31'b0, stall_out}, 32'h1);
    @(negedge clk);
    rollback_ack = 1'b1;
    vote_valid   = 1'b1;
    Voter_state  = 3'b000;
    MemWrite     = 1'b1;
    #1;
    chk("hold_mws_gated", {31'b0, mem_write_safe}, 32'h0);
    @(posedge clk);
    #1;
    idle_in();
    cyc(3);
    chk("hold_resync_req", {31'b0, resync_req}, 32'h1);
    chk("hold_no_rollback", {31'b0, rollback_req}, 32'h0);
    chk("hold_resync_pc", resync_pc, 32'h44);
    @(negedge clk);
    resync_ack  = 1'b1;
    vote_valid  = 1'b1;
    Voter_state = 3'b010;
    @(posedge clk);
    #1;
    idle_in();
    chk("ackfault_resync_req", {31'b0, resync_req}, 32'h0);
    chk("ackfault_fault_core", {29'b0, fault_core}, 32'h0);
    chk("ackfault_stall", {31'b0, stall_out}, 32'h0);

    // threshold retirement, then second core reaching threshold halts
    do_reset();
    for (int k = 0; k < 3; k++) begin
      vote(3'b100, 32'h100 + 32'(k), 1'b0);
      chk($sformatf("thC%0d_resync", k), {31'b0, resync_req}, 32'h1);
      ack_rs();
    end
    vote(3'b100, 32'h110, 1'b0);
    chk("thC_disable", {29'b0, core_disable}, 32'h4);
    chk("thC_no_resync", {31'b0, resync_req}, 32'h0);
    chk("thC_no_stall", {31'b0, stall_out}, 32'h0);
    vote(3'b100, 32'h114, 1'b0);
    chk("thC_ignored", {31'b0, resync_req}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      vote(3'b001, 32'h200 + 32'(k), 1'b0);
      chk($sformatf("thB%0d_fault_core", k), {29'b0, fault_core}, 32'h2);
      ack_rs();
    end
    vote(3'b001, 32'h210, 1'b0);
    chk("thB_disable", {29'b0, core_disable}, 32'h6);
    chk("thB_halt", {31'b0, halt}, 32'h1);
    vote(3'b111, 32'h220, 1'b0);
    cyc(2);
    chk("halt_sticky", {31'b0, halt}, 32'h1);
    chk("halt_stall", {31'b0, stall_out}, 32'h1);

    // rollback limit with no forward progress
    do_reset();
    vote(3'b111, 32'h80, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vote_valid  = 1'b1;
      Voter_state = 3'b000;
      PC_Top      = 32'h84;
      MemWrite    = 1'b1;
      #1;
      chk($sformatf("rb%0d_mws", k), {31'b0, mem_write_safe}, 32'h0);
      @(posedge clk);
      #1;
      idle_in();
      chk($sformatf("rb%0d_req", k), {31'b0, rollback_req}, 32'h1);
      chk($sformatf("rb%0d_pc", k), rollback_pc, 32'h80);
      ack_rb();
      vote(3'b111, 32'h80, 1'b0);
    end
    vote(3'b000, 32'h84, 1'b0);
    chk("rb_limit_halt", {31'b0, halt}, 32'h1);
    chk("rb_limit_req", {31'b0, rollback_req}, 32'h0);

    // ack timeout in RESYNC
    do_reset();
    vote(3'b100, 32'h90, 1'b0);
    held = 1'b1;
    for (int k = 0; k < 63; k++) begin
      cyc(1);
      held = held & resync_req & ~halt;
    end
    chk("to_held_63", {31'b0, held}, 32'h1);
    cyc(1);
    chk("to_halt", {31'b0, halt}, 32'h1);
    chk("to_resync_req", {31'b0, resync_req}, 32'h0);
    chk("to_stall", {31'b0, stall_out}, 32'h1);

    // asynchronous reset mid-rollback
    do_reset();
    vote(3'b100, 32'hA0, 1'b0);
    ack_rs();
    vote(3'b000, 32'hA4, 1'b0);
    chk("mid_rb_req", {31'b0, rollback_req}, 32'h1);
    #2;
    rst_in = 1'b1;
    #1;
    chk("arst_rollback_req", {31'b0, rollback_req}, 32'h0);
    chk("arst_stall", {31'b0, stall_out}, 32'h0);
    chk("arst_resync_pc", resync_pc, 32'h0);
    @(negedge clk);
    rst_in = 1'b0;

`ifdef TMR_FAULT_LOG_EN
    do_reset();
    vote(3'b100, 32'h10, 1'b0);
    ack_rs();
    vote(3'b010, 32'h20, 1'b0);
    ack_rs();
    chk("log_pc", fault_log_pc, 32'h20);
    chk("log_total", {16'b0, fault_log_total}, 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
